// File: rtl/ti3_unmask_collector.sv
// ti3_unmask_collector
// Share-recombination back end for the 3-share TI datapath. Collects one
// 3-share nibble per handshake beat (nibble 0 first), then recombines the
// shares over two registered XOR stages so that no combinational cone ever
// sees all three shares of a nibble at once.
// Optional build macro: TI3_UNMASK_ZEROIZE_EN clears the share and partial
// registers on handshake and clears m_data one cycle after m_valid falls.
module ti3_unmask_collector #(
  parameter int NIBBLES = 16,
  parameter int CW      = $clog2(NIBBLES)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 s_valid,
  output logic                 s_ready,
  input  logic [3:0]           s_sh1,
  input  logic [3:0]           s_sh2,
  input  logic [3:0]           s_sh3,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic [4*NIBBLES-1:0] m_data,
  output logic                 busy
);

  localparam int W = 4 * NIBBLES;
  localparam logic [CW-1:0] LAST = CW'(NIBBLES - 1);

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    COMB1   = 2'd1,
    COMB2   = 2'd2,
    HOLD    = 2'd3
  } state_t;

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic          r_s_ready;
  logic          r_m_valid;
  logic [W-1:0]  r_sh1;
  logic [W-1:0]  r_sh2;
  logic [W-1:0]  r_sh3;
  logic [W-1:0]  r_p;
  logic [W-1:0]  r_m_data;
`ifdef TI3_UNMASK_ZEROIZE_EN
  logic          r_zero_pend;
`endif

  logic          w_beat;
  logic          w_last;
  logic          w_hs;
  logic [CW+1:0] w_slot;

  // Beat accepted only in COLLECT; the HOLD handshake returns to COLLECT.
  assign w_beat = s_valid & r_s_ready & (r_state == COLLECT);
  assign w_last = w_beat & (r_cnt == LAST);
  assign w_hs   = (r_state == HOLD) & m_ready;
  assign w_slot = {r_cnt, 2'b00};

  // Control FSM: state, beat counter and registered handshake outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= COLLECT;
      r_cnt     <= '0;
      r_s_ready <= 1'b1;
      r_m_valid <= 1'b0;
    end else begin
      case (r_state)
        COLLECT: begin
          if (w_beat) begin
            if (w_last) begin
              r_cnt     <= '0;
              r_s_ready <= 1'b0;
              r_state   <= COMB1;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
        end
        COMB1: begin
          r_state <= COMB2;
        end
        COMB2: begin
          r_m_valid <= 1'b1;
          r_state   <= HOLD;
        end
        HOLD: begin
          if (m_ready) begin
            r_m_valid <= 1'b0;
            r_s_ready <= 1'b1;
            r_state   <= COLLECT;
          end
        end
        default: begin
          r_state   <= COLLECT;
          r_cnt     <= '0;
          r_s_ready <= 1'b1;
          r_m_valid <= 1'b0;
        end
      endcase
    end
  end

  // Share capture: each share lands in its own register, nibble slot cnt.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sh1 <= '0;
      r_sh2 <= '0;
      r_sh3 <= '0;
    end else begin
      if (w_beat) begin
        r_sh1[w_slot +: 4] <= s_sh1;
        r_sh2[w_slot +: 4] <= s_sh2;
        r_sh3[w_slot +: 4] <= s_sh3;
      end
`ifdef TI3_UNMASK_ZEROIZE_EN
      else if (w_hs) begin
        r_sh1 <= '0;
        r_sh2 <= '0;
        r_sh3 <= '0;
      end
`endif
    end
  end

  // Two-stage recombination: p = sh1^sh2, then m_data = p^sh3.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_p      <= '0;
      r_m_data <= '0;
`ifdef TI3_UNMASK_ZEROIZE_EN
      r_zero_pend <= 1'b0;
`endif
    end else begin
`ifdef TI3_UNMASK_ZEROIZE_EN
      r_zero_pend <= w_hs;
      if (r_zero_pend) begin
        r_m_data <= '0;
      end
      if (w_hs) begin
        r_p <= '0;
      end
`endif
      if (r_state == COMB1) begin
        r_p <= r_sh1 ^ r_sh2;
      end
      if (r_state == COMB2) begin
        r_m_data <= r_p ^ r_sh3;
      end
    end
  end

  assign s_ready = r_s_ready;
  assign m_valid = r_m_valid;
  assign m_data  = r_m_data;
  assign busy    = (r_state != COLLECT) | (r_cnt != '0);

endmodule

// File: tb/tb_ti3_unmask_collector.sv
// Directed bench for ti3_unmask_collector (NIBBLES = 16).
module tb_ti3_unmask_collector;

  localparam int NIB = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          s_valid;
  logic          s_ready;
  logic [3:0]    s_sh1, s_sh2, s_sh3;
  logic          m_valid;
  logic          m_ready;
  logic [63:0]   m_data;
  logic          busy;

  int total = 0;
  int bad   = 0;

  ti3_unmask_collector #(.NIBBLES(NIB)) dut (
    .clk     (clk),
    .rst     (rst),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .s_sh1   (s_sh1),
    .s_sh2   (s_sh2),
    .s_sh3   (s_sh3),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .m_data  (m_data),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] sh1;
    logic [63:0] sh2;
    logic [63:0] pt;
    logic [31:0] vmask;
    int          hold;
    bit          mr_early;
  } vec_t;

  vec_t vecs [4];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive n beats of a word; s_valid per cycle follows vmask (repeating).
  task automatic send_beats(input logic [63:0] sh1, input logic [63:0] sh2,
                            input logic [63:0] sh3, input logic [31:0] vmask,
                            input int n, output bit ok);
    int k = 0;
    int g = 0;
    logic rdy;
    while (k < n && g < 200) begin
      @(negedge clk);
      rdy     = s_ready;
      s_valid = vmask[g % 32];
      s_sh1   = sh1[4*k +: 4];
      s_sh2   = sh2[4*k +: 4];
      s_sh3   = sh3[4*k +: 4];
      @(posedge clk);
      if (s_valid && rdy) k++;
      g++;
    end
    ok = (k == n);
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    logic [63:0] sh3;
    bit ok;
    string tag;
    tag = $sformatf("v%0d", idx);
    m_ready = v.mr_early;
    sh3 = v.pt ^ v.sh1 ^ v.sh2;
    send_beats(v.sh1, v.sh2, sh3, v.vmask, NIB, ok);
    chk({tag, "_beats_accepted"}, 64'(ok), 64'd1);
    @(negedge clk);
    s_valid = 1'b0;
    chk({tag, "_comb1_mvalid"}, 64'(m_valid), 64'd0);
    chk({tag, "_comb1_sready"}, 64'(s_ready), 64'd0);
    chk({tag, "_comb1_busy"}, 64'(busy), 64'd1);
    @(negedge clk);
    chk({tag, "_comb2_mvalid"}, 64'(m_valid), 64'd0);
    @(negedge clk);
    chk({tag, "_lat_mvalid"}, 64'(m_valid), 64'd1);
    chk({tag, "_data"}, m_data, v.pt);
    if (!v.mr_early) begin
      s_valid = 1'b1;
      s_sh1 = 4'hF; s_sh2 = 4'h3; s_sh3 = 4'h9;
      for (int i = 0; i < v.hold; i++) begin
        @(negedge clk);
        chk({tag, "_hold_sready"}, 64'(s_ready), 64'd0);
        chk({tag, "_hold_mvalid"}, 64'(m_valid), 64'd1);
        chk({tag, "_hold_data"}, m_data, v.pt);
        chk({tag, "_hold_busy"}, 64'(busy), 64'd1);
      end
      m_ready = 1'b1;
    end
    @(negedge clk);
    chk({tag, "_post_mvalid"}, 64'(m_valid), 64'd0);
    chk({tag, "_post_sready"}, 64'(s_ready), 64'd1);
    chk({tag, "_post_busy"}, 64'(busy), 64'd0);
    s_valid = 1'b0;
    m_ready = 1'b0;
    @(negedge clk);
`ifdef TI3_UNMASK_ZEROIZE_EN
    chk({tag, "_zeroized_data"}, m_data, 64'd0);
`else
    chk({tag, "_retained_data"}, m_data, v.pt);
`endif
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    bit ok;
    logic [63:0] a_sh1, a_sh2, a_pt, b_sh1, b_sh2, b_pt;
    int k, w, t0, t1;
    logic rdy;

    vecs[0] = '{sh1: 64'hFEDC_BA98_7654_3210, sh2: 64'hAAAA_AAAA_AAAA_AAAA,
                pt: 64'h5555_5555_5555_5555, vmask: 32'hFFFF_FFFF, hold: 0, mr_early: 1'b0};
    vecs[1] = '{sh1: 64'h3C5A_9F01_7E2D_B468, sh2: 64'hD1E2_F304_1526_3748,
                pt: 64'h0123_4567_89AB_CDEF, vmask: 32'hAAAA_AAAA, hold: 10, mr_early: 1'b0};
    vecs[2] = '{sh1: 64'h0F0F_0F0F_0F0F_0F0F, sh2: 64'h7777_7777_7777_7777,
                pt: 64'hFFFF_FFFF_FFFF_FFFF, vmask: 32'hFFFF_FFFF, hold: 0, mr_early: 1'b1};
    vecs[3] = '{sh1: 64'hA5A5_A5A5_A5A5_A5A5, sh2: 64'h5A5A_C3C3_9696_1E1E,
                pt: 64'h0000_0000_0000_0000, vmask: 32'h9D3B_6E51, hold: 2, mr_early: 1'b0};

    rst = 1'b1; s_valid = 1'b0; m_ready = 1'b0;
    s_sh1 = '0; s_sh2 = '0; s_sh3 = '0;
    #12;
    chk("rst_sready", 64'(s_ready), 64'd1);
    chk("rst_mvalid", 64'(m_valid), 64'd0);
    chk("rst_mdata", m_data, 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 4; i++) run_vec(vecs[i], i);

    // Reset after 7 beats: partial word discarded, outputs back to reset values.
    send_beats(64'h1234_5678_9ABC_DEF0, 64'hFFFF_0000_FFFF_0000,
               64'h0F0F_F0F0_0F0F_F0F0, 32'hFFFF_FFFF, 7, ok);
    chk("part7_accepted", 64'(ok), 64'd1);
    @(negedge clk);
    s_valid = 1'b0;
    chk("part7_busy", 64'(busy), 64'd1);
    #2 rst = 1'b1;
    #1;
    chk("midcol_rst_sready", 64'(s_ready), 64'd1);
    chk("midcol_rst_mvalid", 64'(m_valid), 64'd0);
    chk("midcol_rst_mdata", m_data, 64'd0);
    chk("midcol_rst_busy", 64'(busy), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    run_vec(vecs[1], 4);

    // Reset during HOLD: m_valid drops without a clock edge.
    a_sh1 = 64'h1111_2222_3333_4444; a_sh2 = 64'h9999_8888_7777_6666;
    a_pt  = 64'hCAFE_F00D_1234_ABCD;
    send_beats(a_sh1, a_sh2, a_pt ^ a_sh1 ^ a_sh2, 32'hFFFF_FFFF, NIB, ok);
    @(negedge clk); s_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("hold_pre_rst_mvalid", 64'(m_valid), 64'd1);
    chk("hold_pre_rst_data", m_data, a_pt);
    #2 rst = 1'b1;
    #1;
    chk("hold_rst_mvalid", 64'(m_valid), 64'd0);
    chk("hold_rst_mdata", m_data, 64'd0);
    chk("hold_rst_sready", 64'(s_ready), 64'd1);
    chk("hold_rst_busy", 64'(busy), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    run_vec(vecs[0], 5);

    // Back-to-back words with m_ready tied high: NIB+3 cycle period.
    a_sh1 = 64'h1111_1111_1111_1111; a_sh2 = 64'h2468_ACE0_1357_9BDF;
    a_pt  = 64'hDEAD_BEEF_0BAD_F00D;
    b_sh1 = 64'hF0E1_D2C3_B4A5_9687; b_sh2 = 64'h3333_CCCC_5555_AAAA;
    b_pt  = 64'h0F1E_2D3C_4B5A_6978;
    m_ready = 1'b1;
    k = 0; w = 0; t0 = 0; t1 = 0;
    for (int g = 0; g < 100 && w < 2; g++) begin
      @(negedge clk);
      if (m_valid) begin
        if (w == 0) begin
          t0 = g;
          chk("b2b_word0", m_data, a_pt);
        end else begin
          t1 = g;
          chk("b2b_word1", m_data, b_pt);
        end
        w++;
      end
      rdy = s_ready;
      s_valid = (k < 2*NIB);
      if (k < NIB) begin
        s_sh1 = a_sh1[4*k +: 4];
        s_sh2 = a_sh2[4*k +: 4];
        s_sh3 = a_pt[4*k +: 4] ^ a_sh1[4*k +: 4] ^ a_sh2[4*k +: 4];
      end else if (k < 2*NIB) begin
        s_sh1 = b_sh1[4*(k-NIB) +: 4];
        s_sh2 = b_sh2[4*(k-NIB) +: 4];
        s_sh3 = b_pt[4*(k-NIB) +: 4] ^ b_sh1[4*(k-NIB) +: 4] ^ b_sh2[4*(k-NIB) +: 4];
      end
      @(posedge clk);
      if (s_valid && rdy) k++;
    end
    chk("b2b_words_seen", 64'(w), 64'd2);
    chk("b2b_period", 64'(t1 - t0), 64'(NIB + 3));
    s_valid = 1'b0;
    @(negedge clk);
    chk("b2b_end_mvalid", 64'(m_valid), 64'd0);
    chk("b2b_end_busy", 64'(busy), 64'd0);
    m_ready = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
